// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA line fetcher: fetch FSM states and
// line-buffer geometry.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    UNPACK  = 2'd2
  } fetch_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BANK_BYTES     = 1024;
  localparam int MAX_LINE_WORDS = 256;

endpackage

// File: rtl/vga_word_unpacker.sv
// Splits one 32-bit framebuffer word into four RGB332 pixel writes on
// consecutive cycles, lowest byte first.
module vga_word_unpacker
  import vga_pkg::BYTES_PER_WORD;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] word_i,
  output logic        valid_o,
  output logic [7:0]  byte_o,
  output logic [1:0]  index_o,
  output logic        last_o
);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;
  logic        active_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (flush_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (load_i) begin
      word_q   <= word_i;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      word_q <= word_q >> 8;
      cnt_q  <= cnt_q + 2'd1;
      if (last_o) active_q <= 1'b0;
    end
  end

  assign valid_o = active_q;
  assign byte_o  = word_q[7:0];
  assign index_o = cnt_q;
  assign last_o  = active_q && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/vga_line_fetcher.sv
// Fetches one scan line per driver request from the framebuffer into the
// back bank of a ping-pong line buffer; handles frame restart and double scan.
module vga_line_fetcher
  import vga_pkg::fetch_state_e, vga_pkg::IDLE, vga_pkg::REQUEST, vga_pkg::UNPACK,
         vga_pkg::BYTES_PER_WORD;
#(
  parameter int BANK_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] frameBase,
  input  logic [31:0] lineStride,
  input  logic [8:0]  lineWords,
  input  logic        doubleScan,
  input  logic        lineRequest,
  input  logic        endOfFrame,
  input  logic        clearUnderrun,
  output logic        memRequest,
  output logic [31:0] memAddress,
  input  logic        memAck,
  input  logic [31:0] memReadData,
  output logic        writeEnable,
  output logic [10:0] writeAddress,
  output logic [7:0]  writeData,
  output logic        displayBank,
  output logic        busy,
  output logic        underrun
);

  localparam int MAX_WORDS = BANK_BYTES / BYTES_PER_WORD;

  fetch_state_e state_q, state_d;
  logic [31:0]  line_addr_q, line_addr_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [8:0]   word_count_q, word_count_d;
  logic [8:0]   line_words_q, line_words_d;
  logic         repeat_q, repeat_d;
  logic         disp_bank_q, disp_bank_d;
  logic         fetch_bank_q, fetch_bank_d;
  logic         abort_q, abort_d;
  logic         underrun_q, underrun_d;

  logic         unp_load, unp_flush, unp_valid, unp_last;
  logic [7:0]   unp_byte;
  logic [1:0]   unp_idx;

  logic [8:0]   words_clamped;
  logic         frame_ev, swap_ev, repeat_ev, fetch_ev, launch;

  assign words_clamped = (int'(lineWords) > MAX_WORDS) ? 9'(MAX_WORDS) : lineWords;

  // endOfFrame has priority; a coincident lineRequest is dropped entirely.
  assign frame_ev  = endOfFrame;
  assign swap_ev   = lineRequest && !endOfFrame && !repeat_q;
  assign repeat_ev = lineRequest && !endOfFrame && repeat_q;
  assign fetch_ev  = frame_ev || swap_ev;

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    mem_addr_d   = mem_addr_q;
    word_count_d = word_count_q;
    line_words_d = line_words_q;
    repeat_d     = repeat_q;
    disp_bank_d  = disp_bank_q;
    fetch_bank_d = fetch_bank_q;
    abort_d      = abort_q;
    underrun_d   = underrun_q;
    unp_load     = 1'b0;
    unp_flush    = 1'b0;
    launch       = 1'b0;

    if (clearUnderrun) underrun_d = 1'b0;
    if (lineRequest && !endOfFrame && (state_q != IDLE)) underrun_d = 1'b1;

    if (frame_ev) begin
      line_addr_d = frameBase;
      repeat_d    = 1'b0;
    end else if (swap_ev) begin
      disp_bank_d = !disp_bank_q;
      line_addr_d = line_addr_q + lineStride;
      repeat_d    = doubleScan;
    end else if (repeat_ev) begin
      repeat_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (fetch_ev) launch = 1'b1;
      end
      REQUEST: begin
        if (memAck) begin
          // A superseded request completes its handshake but its data is dropped.
          if (abort_q || fetch_ev) begin
            launch = 1'b1;
          end else begin
            unp_load = 1'b1;
            state_d  = UNPACK;
          end
        end else if (fetch_ev) begin
          abort_d = 1'b1;
        end
      end
      UNPACK: begin
        if (fetch_ev) begin
          unp_flush = 1'b1;
          launch    = 1'b1;
        end else if (unp_last) begin
          if ((word_count_q + 9'd1) < line_words_q) begin
            word_count_d = word_count_q + 9'd1;
            mem_addr_d   = mem_addr_q + 32'd4;
            state_d      = REQUEST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      abort_d      = 1'b0;
      word_count_d = '0;
      line_words_d = words_clamped;
      fetch_bank_d = !disp_bank_d;
      mem_addr_d   = {line_addr_d[31:2], 2'b00};
      state_d      = (words_clamped == 9'd0) ? IDLE : REQUEST;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      line_addr_q  <= '0;
      mem_addr_q   <= '0;
      word_count_q <= '0;
      line_words_q <= '0;
      repeat_q     <= 1'b0;
      disp_bank_q  <= 1'b0;
      fetch_bank_q <= 1'b0;
      abort_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      mem_addr_q   <= mem_addr_d;
      word_count_q <= word_count_d;
      line_words_q <= line_words_d;
      repeat_q     <= repeat_d;
      disp_bank_q  <= disp_bank_d;
      fetch_bank_q <= fetch_bank_d;
      abort_q      <= abort_d;
      underrun_q   <= underrun_d;
    end
  end

  vga_word_unpacker u_unpacker (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (unp_load),
    .flush_i (unp_flush),
    .word_i  (memReadData),
    .valid_o (unp_valid),
    .byte_o  (unp_byte),
    .index_o (unp_idx),
    .last_o  (unp_last)
  );

  assign memRequest   = (state_q == REQUEST);
  assign memAddress   = mem_addr_q;
  assign busy         = (state_q != IDLE);
  assign writeEnable  = unp_valid;
  assign writeAddress = {fetch_bank_q, word_count_q[7:0], unp_idx};
  assign writeData    = unp_byte;
  assign displayBank  = disp_bank_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Directed bench for vga_line_fetcher: a framebuffer responder whose byte at
// address b is b[7:0]^b[15:8], plus write/request loggers checked per step.
module tb_vga_line_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] frameBase, lineStride;
  logic [8:0]  lineWords;
  logic        doubleScan, lineRequest, endOfFrame, clearUnderrun;
  logic        memRequest, memAck;
  logic [31:0] memAddress, memReadData;
  logic        writeEnable, displayBank, busy, underrun;
  logic [10:0] writeAddress;
  logic [7:0]  writeData;

  int vectors = 0;
  int miscompares = 0;
  logic ack_hold = 1'b0;

  logic [31:0] req_q[$];
  logic [10:0] wr_a[$];
  logic [7:0]  wr_d[$];

  always #5 clk = ~clk;

  vga_line_fetcher dut (
    .clk           (clk),
    .reset         (reset),
    .frameBase     (frameBase),
    .lineStride    (lineStride),
    .lineWords     (lineWords),
    .doubleScan    (doubleScan),
    .lineRequest   (lineRequest),
    .endOfFrame    (endOfFrame),
    .clearUnderrun (clearUnderrun),
    .memRequest    (memRequest),
    .memAddress    (memAddress),
    .memAck        (memAck),
    .memReadData   (memReadData),
    .writeEnable   (writeEnable),
    .writeAddress  (writeAddress),
    .writeData     (writeData),
    .displayBank   (displayBank),
    .busy          (busy),
    .underrun      (underrun)
  );

  function automatic logic [7:0] exp_pix(input logic [31:0] b);
    return b[7:0] ^ b[15:8];
  endfunction

  function automatic logic [31:0] pix_word(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = exp_pix(a + 32'(k));
    return w;
  endfunction

  // Memory responder: acks one cycle after a request is seen, unless held.
  initial begin
    int wait_n;
    wait_n = 0;
    memAck = 1'b0;
    memReadData = '0;
    forever begin
      @(negedge clk);
      if (memAck) begin
        memAck = 1'b0;
      end else if (memRequest && !ack_hold) begin
        wait_n++;
        if (wait_n >= 2) begin
          memAck = 1'b1;
          memReadData = pix_word(memAddress);
          req_q.push_back(memAddress);
          wait_n = 0;
        end
      end else begin
        wait_n = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (writeEnable) begin
      wr_a.push_back(writeAddress);
      wr_d.push_back(writeData);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    req_q.delete();
    wr_a.delete();
    wr_d.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || memRequest) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse(input logic eof, input logic lreq, input logic clr);
    @(negedge clk);
    endOfFrame = eof;
    lineRequest = lreq;
    clearUnderrun = clr;
    @(negedge clk);
    endOfFrame = 1'b0;
    lineRequest = 1'b0;
    clearUnderrun = 1'b0;
  endtask

  task automatic check_line(input string tag, input int n, input logic [10:0] wbase,
                            input logic [31:0] line);
    chk({tag, "_wcount"}, 32'(wr_a.size()), 32'(n));
    for (int i = 0; i < n && i < wr_a.size(); i++) begin
      chk({tag, "_waddr"}, {21'd0, wr_a[i]}, {21'd0, wbase + 11'(i)});
      chk({tag, "_wdata"}, {24'd0, wr_d[i]}, {24'd0, exp_pix(line + 32'(i))});
    end
  endtask

  initial begin
    reset = 1'b0;
    frameBase = 32'h0000_1000;
    lineStride = 32'h0000_0200;
    lineWords = 9'd2;
    doubleScan = 1'b0;
    lineRequest = 1'b0;
    endOfFrame = 1'b0;
    clearUnderrun = 1'b0;
    cycles(3);

    // Reset state
    chk("rst_memRequest", {31'd0, memRequest}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_displayBank", {31'd0, displayBank}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_writeEnable", {31'd0, writeEnable}, 32'd0);
    chk("rst_memAddress", memAddress, 32'd0);
    reset = 1'b1;
    cycles(2);

    // Frame prefetch of line 0 into bank 1
    clear_logs();
    pulse(1'b1, 1'b0, 1'b0);
    chk("eof_memRequest_t1", {31'd0, memRequest}, 32'd1);
    chk("eof_busy_t1", {31'd0, busy}, 32'd1);
    chk("eof_memAddress", memAddress, 32'h1000);
    wait_idle("eof_idle", 200);
    chk("eof_reqs", 32'(req_q.size()), 32'd2);
    if (req_q.size() >= 2) begin
      chk("eof_req0", req_q[0], 32'h1000);
      chk("eof_req1", req_q[1], 32'h1004);
    end
    check_line("eof", 8, 11'h400, 32'h1000);
    chk("eof_displayBank", {31'd0, displayBank}, 32'd0);

    // Normal line request: swap and fetch next line into bank 0
    clear_logs();
    pulse(1'b0, 1'b1, 1'b0);
    chk("lr_displayBank", {31'd0, displayBank}, 32'd1);
    chk("lr_memAddress", memAddress, 32'h1200);
    wait_idle("lr_idle", 200);
    check_line("lr", 8, 11'h000, 32'h1200);

    // Double scan: restart frame, then swap / repeat / swap
    pulse(1'b1, 1'b0, 1'b0);
    wait_idle("ds_eof_idle", 200);
    doubleScan = 1'b1;
    clear_logs();
    pulse(1'b0, 1'b1, 1'b0);
    chk("ds1_displayBank", {31'd0, displayBank}, 32'd0);
    wait_idle("ds1_idle", 200);
    chk("ds1_req0", (req_q.size() > 0) ? req_q[0] : 32'hDEAD, 32'h1200);
    check_line("ds1", 8, 11'h400, 32'h1200);
    clear_logs();
    pulse(1'b0, 1'b1, 1'b0);
    chk("ds2_memRequest", {31'd0, memRequest}, 32'd0);
    chk("ds2_busy", {31'd0, busy}, 32'd0);
    chk("ds2_displayBank", {31'd0, displayBank}, 32'd0);
    cycles(6);
    chk("ds2_reqs", 32'(req_q.size()), 32'd0);
    chk("ds2_writes", 32'(wr_a.size()), 32'd0);
    doubleScan = 1'b0;
    clear_logs();
    pulse(1'b0, 1'b1, 1'b0);
    chk("ds3_displayBank", {31'd0, displayBank}, 32'd1);
    wait_idle("ds3_idle", 200);
    chk("ds3_req0", (req_q.size() > 0) ? req_q[0] : 32'hDEAD, 32'h1400);
    check_line("ds3", 8, 11'h000, 32'h1400);

    // Underrun: request 0x1600 stalls, second lineRequest mid-fetch
    clear_logs();
    ack_hold = 1'b1;
    pulse(1'b0, 1'b1, 1'b0);
    cycles(5);
    chk("ur_memRequest_held", {31'd0, memRequest}, 32'd1);
    chk("ur_memAddress", memAddress, 32'h1600);
    chk("ur_underrun_before", {31'd0, underrun}, 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("ur_underrun", {31'd0, underrun}, 32'd1);
    chk("ur_displayBank", {31'd0, displayBank}, 32'd1);
    cycles(11);
    chk("ur_memRequest_still", {31'd0, memRequest}, 32'd1);
    chk("ur_memAddress_stable", memAddress, 32'h1600);
    ack_hold = 1'b0;
    wait_idle("ur_idle", 300);
    chk("ur_reqs", 32'(req_q.size()), 32'd3);
    if (req_q.size() >= 3) begin
      chk("ur_req0", req_q[0], 32'h1600);
      chk("ur_req1", req_q[1], 32'h1800);
      chk("ur_req2", req_q[2], 32'h1804);
    end
    check_line("ur", 8, 11'h000, 32'h1800);
    chk("ur_sticky", {31'd0, underrun}, 32'd1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("ur_cleared", {31'd0, underrun}, 32'd0);

    // Coincident endOfFrame + lineRequest: frame prefetch only
    frameBase = 32'h0000_2000;
    clear_logs();
    pulse(1'b1, 1'b1, 1'b0);
    chk("both_displayBank", {31'd0, displayBank}, 32'd1);
    chk("both_memAddress", memAddress, 32'h2000);
    wait_idle("both_idle", 200);
    chk("both_underrun", {31'd0, underrun}, 32'd0);
    chk("both_reqs", 32'(req_q.size()), 32'd2);
    check_line("both", 8, 11'h000, 32'h2000);

    // lineWords above 256 clamps to a full 1024-byte bank
    lineWords = 9'd300;
    clear_logs();
    pulse(1'b0, 1'b1, 1'b0);
    chk("clamp_displayBank", {31'd0, displayBank}, 32'd0);
    wait_idle("clamp_idle", 5000);
    chk("clamp_reqs", 32'(req_q.size()), 32'd256);
    chk("clamp_lastreq", (req_q.size() > 0) ? req_q[req_q.size()-1] : 32'hDEAD, 32'h25FC);
    chk("clamp_writes", 32'(wr_a.size()), 32'd1024);
    if (wr_a.size() == 1024) begin
      chk("clamp_first_addr", {21'd0, wr_a[0]}, 32'h400);
      chk("clamp_last_addr", {21'd0, wr_a[1023]}, 32'h7FF);
      chk("clamp_last_data", {24'd0, wr_d[1023]}, 32'hDA);
    end

    // lineWords = 0: bank swaps, nothing fetched
    lineWords = 9'd0;
    clear_logs();
    pulse(1'b0, 1'b1, 1'b0);
    chk("zero_memRequest", {31'd0, memRequest}, 32'd0);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_displayBank", {31'd0, displayBank}, 32'd1);
    cycles(5);
    chk("zero_reqs", 32'(req_q.size()), 32'd0);

    // Async reset in the middle of a held request
    lineWords = 9'd2;
    ack_hold = 1'b1;
    pulse(1'b0, 1'b1, 1'b0);
    cycles(2);
    chk("ar_memRequest_before", {31'd0, memRequest}, 32'd1);
    chk("ar_memAddress_before", memAddress, 32'h2600);
    #2 reset = 1'b0;
    #1;
    chk("ar_memRequest", {31'd0, memRequest}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_displayBank", {31'd0, displayBank}, 32'd0);
    chk("ar_underrun", {31'd0, underrun}, 32'd0);
    chk("ar_writeEnable", {31'd0, writeEnable}, 32'd0);
    chk("ar_writeAddress", {21'd0, writeAddress}, 32'd0);
    chk("ar_writeData", {24'd0, writeData}, 32'd0);
    chk("ar_memAddress", memAddress, 32'd0);
    ack_hold = 1'b0;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
